// File: rtl/regbank_ctrl_if.sv
// Bus between the command sequencer, its command source and the register bank.
// The master side is the sequencer: it consumes commands and drives the bank ports.
interface regbank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [SIZE-1:0]  cmd_dst;
  logic [SIZE-1:0]  cmd_src1;
  logic [SIZE-1:0]  cmd_src2;
  logic [WIDTH-1:0] cmd_imm;
  logic [SIZE-1:0]  a1;
  logic [SIZE-1:0]  a2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we3;
  logic [SIZE-1:0]  a3;
  logic [WIDTH-1:0] wd3;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rd1, rd2,
    output cmd_ready, a1, a2, we3, a3, wd3, done, result
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rd1, rd2,
    input  cmd_ready, a1, a2, we3, a3, wd3, done, result
  );
endinterface

// File: rtl/regbank_ctrl.sv
// Register-transfer sequencer: IDLE -> READ -> EXEC -> WRITE, one command per 4 cycles.
// Define REGBANK_CTRL_FLAGS_EN to add the registered zero/carry flag outputs zf and cf.
module regbank_ctrl #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef REGBANK_CTRL_FLAGS_EN
  output logic zf,
  output logic cf,
`endif
  regbank_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  typedef enum logic [1:0] {OP_LOADI = 2'b00, OP_MOVE = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

  state_t           state;
  state_t           next_state;
  op_t              op;
  logic [SIZE-1:0]  dst;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // we3/done decode straight from state so reset removes them without waiting for a clock
  always_comb begin
    next_state    = state;
    bus.cmd_ready = 1'b0;
    bus.we3       = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) next_state = READ;
      end
      READ:  next_state = EXEC;
      EXEC:  next_state = WRITE;
      WRITE: begin
        bus.we3    = 1'b1;
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_LOADI: alu_res = imm;
      OP_MOVE:  alu_res = op_a;
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= OP_LOADI;
      dst        <= '0;
      imm        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      bus.a1     <= '0;
      bus.a2     <= '0;
      bus.a3     <= '0;
      bus.wd3    <= '0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op     <= op_t'(bus.cmd_op);
            dst    <= bus.cmd_dst;
            imm    <= bus.cmd_imm;
            bus.a1 <= bus.cmd_src1;
            bus.a2 <= bus.cmd_src2;
          end
        end
        READ: begin
          op_a <= bus.rd1;
          op_b <= bus.rd2;
        end
        EXEC: begin
          bus.a3  <= dst;
          bus.wd3 <= alu_res;
        end
        WRITE: bus.result <= bus.wd3;
        default: ;
      endcase
    end
  end

`ifdef REGBANK_CTRL_FLAGS_EN
  logic alu_carry;
  logic carry_q;

  // an ADD wrapped exactly when the truncated sum is smaller than an addend
  always_comb begin
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  alu_carry = (alu_res < op_a);
      OP_SUB:  alu_carry = (op_a < op_b);
      default: alu_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zf      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      if (state == EXEC) carry_q <= alu_carry;
      if (state == WRITE) begin
        zf <= (bus.wd3 == '0);
        cf <= carry_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl with a behavioural 4-entry register bank
// that writes on the negedge of the write cycle.
module tb_regbank_ctrl;

  localparam int WIDTH = 4;
  localparam int SIZE  = 2;
  localparam logic [1:0] LOADI = 2'b00;
  localparam logic [1:0] MOVE  = 2'b01;
  localparam logic [1:0] ADD   = 2'b10;
  localparam logic [1:0] SUB   = 2'b11;

  typedef struct {
    logic [1:0]       op;
    logic [SIZE-1:0]  dst;
    logic [SIZE-1:0]  src1;
    logic [SIZE-1:0]  src2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] exp_val;
    logic             exp_zf;
    logic             exp_cf;
  } vec_t;

  vec_t vecs [11];

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   write_count = 0;
  int   wc0;
  logic [WIDTH-1:0] bank [4] = '{default: '0};

  regbank_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

`ifdef REGBANK_CTRL_FLAGS_EN
  logic zf;
  logic cf;
`endif

  regbank_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef REGBANK_CTRL_FLAGS_EN
    .zf    (zf),
    .cf    (cf),
`endif
    .bus   (bus)
  );

  assign bus.rd1 = bank[bus.a1];
  assign bus.rd2 = bank[bus.a2];

  always @(negedge clk) begin
    if (bus.we3) begin
      bank[bus.a3] <= bus.wd3;
      write_count  <= write_count + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one command from IDLE and follows it through every state until it is back in IDLE
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.cmd_op    = v.op;
    bus.cmd_dst   = v.dst;
    bus.cmd_src1  = v.src1;
    bus.cmd_src2  = v.src2;
    bus.cmd_imm   = v.imm;
    bus.cmd_valid = 1'b1;
    checkOutput("ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("ready_read", 32'(bus.cmd_ready), 32'd0);
    checkOutput("a1_read", 32'(bus.a1), 32'(v.src1));
    checkOutput("a2_read", 32'(bus.a2), 32'(v.src2));
    @(negedge clk);
    checkOutput("we3_exec", 32'(bus.we3), 32'd0);
    @(negedge clk);
    checkOutput("we3_write", 32'(bus.we3), 32'd1);
    checkOutput("done_write", 32'(bus.done), 32'd1);
    checkOutput("a3_write", 32'(bus.a3), 32'(v.dst));
    checkOutput("wd3_write", 32'(bus.wd3), 32'(v.exp_val));
    @(negedge clk);
    checkOutput("ready_after", 32'(bus.cmd_ready), 32'd1);
    checkOutput("done_after", 32'(bus.done), 32'd0);
    checkOutput("result", 32'(bus.result), 32'(v.exp_val));
    checkOutput("bank_dst", 32'(bank[v.dst]), 32'(v.exp_val));
`ifdef REGBANK_CTRL_FLAGS_EN
    checkOutput("zf", 32'(zf), 32'(v.exp_zf));
    checkOutput("cf", 32'(cf), 32'(v.exp_cf));
`endif
  endtask

  initial begin
    vec_t fin;
    //           op     dst   src1  src2  imm   exp   zf    cf
    vecs[0]  = '{LOADI, 2'd1, 2'd0, 2'd0, 4'd9, 4'd9,  1'b0, 1'b0};
    vecs[1]  = '{LOADI, 2'd2, 2'd0, 2'd0, 4'd9, 4'd9,  1'b0, 1'b0};
    vecs[2]  = '{ADD,   2'd3, 2'd1, 2'd2, 4'd0, 4'd2,  1'b0, 1'b1};
    vecs[3]  = '{LOADI, 2'd0, 2'd0, 2'd0, 4'd3, 4'd3,  1'b0, 1'b0};
    vecs[4]  = '{LOADI, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5,  1'b0, 1'b0};
    vecs[5]  = '{SUB,   2'd0, 2'd0, 2'd1, 4'd0, 4'd14, 1'b0, 1'b1};
    vecs[6]  = '{SUB,   2'd0, 2'd0, 2'd0, 4'd0, 4'd0,  1'b1, 1'b0};
    vecs[7]  = '{LOADI, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5,  1'b0, 1'b0};
    vecs[8]  = '{MOVE,  2'd2, 2'd1, 2'd3, 4'd0, 4'd5,  1'b0, 1'b0};
    vecs[9]  = '{ADD,   2'd1, 2'd1, 2'd1, 4'd0, 4'd10, 1'b0, 1'b0};
    vecs[10] = '{SUB,   2'd3, 2'd1, 2'd2, 4'd0, 4'd5,  1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dst   = '0;
    bus.cmd_src1  = '0;
    bus.cmd_src2  = '0;
    bus.cmd_imm   = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_we3", 32'(bus.we3), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_a1", 32'(bus.a1), 32'd0);
    checkOutput("rst_a2", 32'(bus.a2), 32'd0);
    checkOutput("rst_a3", 32'(bus.a3), 32'd0);
    checkOutput("rst_wd3", 32'(bus.wd3), 32'd0);
`ifdef REGBANK_CTRL_FLAGS_EN
    checkOutput("rst_zf", 32'(zf), 32'd0);
    checkOutput("rst_cf", 32'(cf), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Back-to-back: valid held high, command fields changed while busy must be ignored
    @(negedge clk);
    wc0 = write_count;
    bus.cmd_op = LOADI; bus.cmd_dst = 2'd2; bus.cmd_src1 = 2'd0; bus.cmd_imm = 4'd7;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_op = MOVE; bus.cmd_dst = 2'd3; bus.cmd_src1 = 2'd2; bus.cmd_src2 = 2'd0; bus.cmd_imm = 4'd0;
    checkOutput("b2b_busy1", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_wd3_1", 32'(bus.wd3), 32'd7);
    checkOutput("b2b_a3_1", 32'(bus.a3), 32'd2);
    @(negedge clk);
    checkOutput("b2b_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    checkOutput("b2b_busy2", 32'(bus.cmd_ready), 32'd0);
    checkOutput("b2b_a1_2", 32'(bus.a1), 32'd2);
    bus.cmd_op = LOADI; bus.cmd_dst = 2'd0; bus.cmd_imm = 4'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_we3_2", 32'(bus.we3), 32'd1);
    checkOutput("b2b_wd3_2", 32'(bus.wd3), 32'd7);
    checkOutput("b2b_a3_2", 32'(bus.a3), 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("b2b_writes", 32'(write_count - wc0), 32'd2);
    checkOutput("b2b_r2", 32'(bank[2]), 32'd7);
    checkOutput("b2b_r3", 32'(bank[3]), 32'd7);
    checkOutput("b2b_r0_kept", 32'(bank[0]), 32'd0);

    // Reset asserted during EXEC of ADD R0 = R1 + R2
    @(negedge clk);
    bus.cmd_op = ADD; bus.cmd_dst = 2'd0; bus.cmd_src1 = 2'd1; bus.cmd_src2 = 2'd2;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    wc0 = write_count;
    rst_n = 1'b0;
    #1;
    checkOutput("exec_rst_we3", 32'(bus.we3), 32'd0);
    checkOutput("exec_rst_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("exec_rst_a1", 32'(bus.a1), 32'd0);
    checkOutput("exec_rst_wd3", 32'(bus.wd3), 32'd0);
    @(negedge clk);
    checkOutput("exec_rst_we3_hold", 32'(bus.we3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("exec_rel_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("exec_rst_writes", 32'(write_count - wc0), 32'd0);
    checkOutput("exec_rst_r0", 32'(bank[0]), 32'd0);
    checkOutput("exec_rst_result", 32'(bus.result), 32'd0);

    // Reset asserted inside the write cycle, before the bank's negedge capture
    @(negedge clk);
    bus.cmd_op = ADD; bus.cmd_dst = 2'd1; bus.cmd_src1 = 2'd1; bus.cmd_src2 = 2'd2;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("wr_rst_we3_before", 32'(bus.we3), 32'd1);
    wc0 = write_count;
    rst_n = 1'b0;
    #1;
    checkOutput("wr_rst_we3_after", 32'(bus.we3), 32'd0);
    checkOutput("wr_rst_done_after", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("wr_rst_writes", 32'(write_count - wc0), 32'd0);
    checkOutput("wr_rst_r1", 32'(bank[1]), 32'd10);

    fin = '{LOADI, 2'd0, 2'd0, 2'd0, 4'd6, 4'd6, 1'b0, 1'b0};
    applyStimulus(fin);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
